// File: rtl/dtcore32_rf_wr_arbiter.sv
// Register-file write-port arbiter: fixed priority to port A with an aging
// counter that force-grants port B, registered single-cycle output stage.
module dtcore32_rf_wr_arbiter #(
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        hold_i,
    input  logic        a_valid_i,
    output logic        a_ready_o,
    input  logic [4:0]  a_rd_addr_i,
    input  logic [31:0] a_wdata_i,
    input  logic        b_valid_i,
    output logic        b_ready_o,
    input  logic [4:0]  b_rd_addr_i,
    input  logic [31:0] b_wdata_i,
    output logic        regfile_wr_en_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] reg_wr_data_o,
    output logic        b_aged_o
);

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              aged;
    logic              a_grant;
    logic              b_grant;
    logic              xfer;
    logic [ADDR_W-1:0] win_rd;
    logic [DATA_W-1:0] win_data;

    logic              wr_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              b_aged_q;

    assign aged = (cnt_q == CNT_W'(MAX_WAIT));

    // Ready depends only on the opposite requester's valid, never on its own.
    always_comb begin
        a_ready_o = !hold_i && !(b_valid_i && aged);
        b_ready_o = !hold_i && (!a_valid_i || aged);
        a_grant   = a_valid_i && a_ready_o;
        b_grant   = b_valid_i && b_ready_o;
        xfer      = a_grant || b_grant;
        win_rd    = b_grant ? b_rd_addr_i : a_rd_addr_i;
        win_data  = b_grant ? b_wdata_i   : a_wdata_i;
    end

    // Aging counter: counts refusals of a continuously valid B request.
    always_comb begin
        cnt_d = cnt_q;
        if (b_grant || !b_valid_i) begin
            cnt_d = '0;
        end else if (hold_i) begin
            cnt_d = cnt_q;
        end else if (!aged) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            b_aged_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            b_aged_q <= (cnt_d == CNT_W'(MAX_WAIT));
        end
    end

    // Output stage; x0 writes are accepted but never enable the regfile.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= xfer && (win_rd != '0);
            if (xfer) begin
                rd_addr_q <= win_rd;
                wr_data_q <= win_data;
            end
        end
    end

    assign regfile_wr_en_o = wr_en_q;
    assign rd_addr_o       = rd_addr_q;
    assign reg_wr_data_o   = wr_data_q;
    assign b_aged_o        = b_aged_q;

endmodule

// File: tb/tb_dtcore32_rf_wr_arbiter.sv
// Bench for dtcore32_rf_wr_arbiter: directed vectors, a per-cycle reference
// model check on every falling edge, and literal expectations per scenario.
module tb_dtcore32_rf_wr_arbiter;

    localparam int MAX_WAIT = 3;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_data, b_data;
    logic        wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] wr_data;
    logic        b_aged;

    int checks   = 0;
    int failures = 0;

    dtcore32_rf_wr_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .hold_i          (hold),
        .a_valid_i       (a_valid),
        .a_ready_o       (a_ready),
        .a_rd_addr_i     (a_rd),
        .a_wdata_i       (a_data),
        .b_valid_i       (b_valid),
        .b_ready_o       (b_ready),
        .b_rd_addr_i     (b_rd),
        .b_wdata_i       (b_data),
        .regfile_wr_en_o (wr_en),
        .rd_addr_o       (rd_addr),
        .reg_wr_data_o   (wr_data),
        .b_aged_o        (b_aged)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: B's count of consecutive refusals, and the write it
    // expects to see on the port after each edge.
    int          waited;
    logic        m_en;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_aged;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waited <= 0;
            m_en   <= 1'b0;
            m_rd   <= '0;
            m_data <= '0;
            m_aged <= 1'b0;
        end else begin
            int  w;
            bit  take_a, take_b;
            take_a = 0;
            take_b = 0;
            if (!hold) begin
                if (b_valid && waited == MAX_WAIT) take_b = 1;
                else if (a_valid)                  take_a = 1;
                else if (b_valid)                  take_b = 1;
            end
            if (!b_valid || take_b)            w = 0;
            else if (hold)                     w = waited;
            else                               w = (waited < MAX_WAIT) ? waited + 1 : MAX_WAIT;
            waited <= w;
            m_aged <= (w == MAX_WAIT);
            if (take_a) begin
                m_en <= (a_rd != 0); m_rd <= a_rd; m_data <= a_data;
            end else if (take_b) begin
                m_en <= (b_rd != 0); m_rd <= b_rd; m_data <= b_data;
            end else begin
                m_en <= 1'b0;
            end
        end
    end

    // Compare DUT against model away from the active edge.
    always @(negedge clk) begin
        chk("m_wr_en",   32'(wr_en),   32'(m_en));
        chk("m_rd_addr", 32'(rd_addr), 32'(m_rd));
        chk("m_wr_data", wr_data,      m_data);
        chk("m_b_aged",  32'(b_aged),  32'(m_aged));
        chk("m_a_ready", 32'(a_ready), 32'(!hold && !(b_valid && waited == MAX_WAIT)));
        chk("m_b_ready", 32'(b_ready), 32'(!hold && (!a_valid || waited == MAX_WAIT)));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_a(input logic v, input logic [4:0] rd, input logic [31:0] d);
        a_valid = v; a_rd = rd; a_data = d;
    endtask

    task automatic set_b(input logic v, input logic [4:0] rd, input logic [31:0] d);
        b_valid = v; b_rd = rd; b_data = d;
    endtask

    initial begin
        rst_n = 1'b0;
        hold  = 1'b0;
        set_a(0, 0, 0);
        set_b(0, 0, 0);
        #3;
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_rd",    32'(rd_addr), 0);
        chk("rst_data",  wr_data, 0);
        chk("rst_aged",  32'(b_aged), 0);
        #9 rst_n = 1'b1;
        cyc();

        // A-only write to x5
        set_a(1, 5, 32'hDEADBEEF);
        #1 chk("t1_a_ready", 32'(a_ready), 1);
        cyc();
        set_a(0, 0, 0);
        chk("t1_wr_en", 32'(wr_en), 1);
        chk("t1_rd",    32'(rd_addr), 5);
        chk("t1_data",  wr_data, 32'hDEADBEEF);
        cyc();
        chk("t1_wr_en_off", 32'(wr_en), 0);

        // Aging: A wins three times, then B is forced through
        set_b(1, 9, 32'h0000_0099);
        for (int i = 0; i < 3; i++) begin
            set_a(1, 5'(i + 1), 32'h100 + 32'(i));
            #1 chk("t2_b_refused", 32'(b_ready), 0);
            cyc();
            chk("t2_a_rd", 32'(rd_addr), 32'(i + 1));
        end
        chk("t2_aged", 32'(b_aged), 1);
        set_a(1, 4, 32'h103);
        #1 chk("t2_a_blocked", 32'(a_ready), 0);
        chk("t2_b_forced", 32'(b_ready), 1);
        cyc();
        set_b(0, 0, 0);
        chk("t2_b_rd",   32'(rd_addr), 9);
        chk("t2_b_data", wr_data, 32'h99);
        chk("t2_aged_clr", 32'(b_aged), 0);
        cyc();
        chk("t2_a_resume", 32'(rd_addr), 4);
        set_a(0, 0, 0);

        // Write to x0 is accepted but dropped
        set_b(1, 0, 32'h12345678);
        #1 chk("t3_b_ready", 32'(b_ready), 1);
        cyc();
        set_b(0, 0, 0);
        chk("t3_wr_en", 32'(wr_en), 0);
        chk("t3_rd",    32'(rd_addr), 0);
        chk("t3_data",  wr_data, 32'h12345678);

        // Hold with B's counter at 2
        set_a(1, 7, 32'h77);
        set_b(1, 10, 32'hAA);
        cyc();
        set_a(1, 8, 32'h88);
        cyc();
        hold = 1'b1;
        set_a(1, 11, 32'hBB);
        #1 chk("t4_a_ready_hold", 32'(a_ready), 0);
        chk("t4_b_ready_hold", 32'(b_ready), 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t4_wr_en_hold", 32'(wr_en), 0);
            chk("t4_aged_hold",  32'(b_aged), 0);
        end
        hold = 1'b0;
        cyc();
        chk("t4_a_after", 32'(rd_addr), 11);
        chk("t4_aged",    32'(b_aged), 1);
        set_a(1, 12, 32'hCC);
        cyc();
        chk("t4_b_after", 32'(rd_addr), 10);
        set_a(0, 0, 0);
        set_b(0, 0, 0);
        cyc();

        // Async reset while a write is on the port
        set_a(1, 3, 32'h33);
        cyc();
        set_a(0, 0, 0);
        chk("t5_pre_en", 32'(wr_en), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_en",   32'(wr_en), 0);
        chk("t5_rst_rd",   32'(rd_addr), 0);
        chk("t5_rst_data", wr_data, 0);
        chk("t5_rst_aged", 32'(b_aged), 0);
        #3 set_b(1, 6, 32'h66);
        #1 rst_n = 1'b1;
        cyc();
        set_b(0, 0, 0);
        chk("t5_b_first_en", 32'(wr_en), 1);
        chk("t5_b_first_rd", 32'(rd_addr), 6);

        // B drops valid after two refusals; count restarts
        set_b(1, 13, 32'hDD);
        set_a(1, 1, 32'h1);
        cyc();
        set_a(1, 2, 32'h2);
        cyc();
        set_b(0, 0, 0);
        set_a(1, 3, 32'h3);
        cyc();
        chk("t6_aged_drop", 32'(b_aged), 0);
        set_b(1, 13, 32'hDD);
        for (int i = 0; i < 3; i++) begin
            set_a(1, 5'(20 + i), 32'h20 + 32'(i));
            #1 chk("t6_b_refused", 32'(b_ready), 0);
            cyc();
        end
        chk("t6_aged", 32'(b_aged), 1);
        set_a(1, 23, 32'h23);
        #1 chk("t6_b_forced", 32'(b_ready), 1);
        cyc();
        chk("t6_b_rd", 32'(rd_addr), 13);
        set_a(0, 0, 0);
        set_b(0, 0, 0);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
